// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer and its range checker.
package calc_pkg;

    localparam int unsigned NB_DEFAULT      = 64;
    localparam logic [63:0] MAX_MAG_DEFAULT = 64'd999_999_999_999;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_MUL   = 3'd2,
        OP_DIV   = 3'd3,
        OP_POW   = 3'd4,
        OP_LOAD  = 3'd5,
        OP_CLEAR = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ERR_OK     = 3'd0,
        ERR_DIV0   = 3'd1,
        ERR_NEGEXP = 3'd2,
        ERR_BADOP  = 3'd3,
        ERR_OVF    = 3'd4
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/calc_range_check.sv
// Combinational signed magnitude test: flags |x| > MAX_MAG, most-negative value always flagged.
module calc_range_check
    import calc_pkg::*;
#(
    parameter int unsigned      NB      = NB_DEFAULT,
    parameter logic [NB-1:0]    MAX_MAG = NB'(MAX_MAG_DEFAULT)
) (
    input  logic [NB-1:0] val_i,
    output logic          ovf_c_o
);

    logic [NB:0] ext_c;
    logic [NB:0] mag_c;
    logic        min_neg_c;

    // One extra bit so negating the most-negative value cannot wrap.
    assign ext_c     = {val_i[NB-1], val_i};
    assign mag_c     = val_i[NB-1] ? (~ext_c) + (NB+1)'(1) : ext_c;
    assign min_neg_c = (val_i == {1'b1, {(NB-1){1'b0}}});
    assign ovf_c_o   = min_neg_c || (mag_c > {1'b0, MAX_MAG});

endmodule

// File: rtl/calc_op_sequencer.sv
// Command sequencer for the 5-op calculator datapath: pre-checks, timed execution,
// result range check, accumulator and error counting.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned   NB      = NB_DEFAULT,
    parameter int unsigned   DP_LAT  = 1,
    parameter logic [NB-1:0] MAX_MAG = NB'(MAX_MAG_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [NB-1:0] cmd_a,
    input  logic [NB-1:0] cmd_b,
    input  logic          cmd_use_acc,
    output logic [NB-1:0] dp_a,
    output logic [NB-1:0] dp_b,
    output logic [2:0]    dp_op,
    input  logic [NB-1:0] dp_result,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [NB-1:0] rsp_result,
    output logic [2:0]    rsp_err,
    output logic [NB-1:0] acc_value,
    output logic [7:0]    err_cnt
);

    localparam int unsigned CNT_W    = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DP_LAT - 1);

    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [NB-1:0]     rsp_result_q, rsp_result_d;
    err_e              rsp_err_q, rsp_err_d;
    logic [NB-1:0]     dp_a_q, dp_a_d;
    logic [NB-1:0]     dp_b_q, dp_b_d;
    logic [2:0]        dp_op_q, dp_op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NB-1:0]     acc_q, acc_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    op_e               op_c;
    logic [NB-1:0]     eff_a_c;
    logic [NB-1:0]     chk_a_c;
    logic              arith_c;
    logic              a_ovf_c, b_ovf_c, r_ovf_c;
    logic              early_c;
    logic              clear_c;
    err_e              early_err_c;
    logic [NB-1:0]     early_res_c;

    assign op_c    = op_e'(cmd_op);
    assign eff_a_c = cmd_use_acc ? acc_q : cmd_a;
    assign chk_a_c = (op_c == OP_LOAD) ? cmd_a : eff_a_c;
    assign arith_c = (cmd_op <= 3'd4);

    calc_range_check #(.NB(NB), .MAX_MAG(MAX_MAG)) u_rc_a (.val_i(chk_a_c),   .ovf_c_o(a_ovf_c));
    calc_range_check #(.NB(NB), .MAX_MAG(MAX_MAG)) u_rc_b (.val_i(cmd_b),     .ovf_c_o(b_ovf_c));
    calc_range_check #(.NB(NB), .MAX_MAG(MAX_MAG)) u_rc_r (.val_i(dp_result), .ovf_c_o(r_ovf_c));

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = cmd_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        dp_a_d       = dp_a_q;
        dp_b_d       = dp_b_q;
        dp_op_d      = dp_op_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        err_cnt_d    = err_cnt_q;
        early_c      = 1'b0;
        clear_c      = 1'b0;
        early_err_c  = ERR_OK;
        early_res_c  = '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    early_c = 1'b1;
                    if (op_c == OP_RSVD) begin
                        early_err_c = ERR_BADOP;
                    end else if ((op_c == OP_DIV) && (cmd_b == '0)) begin
                        early_err_c = ERR_DIV0;
                    end else if ((op_c == OP_POW) && cmd_b[NB-1]) begin
                        early_err_c = ERR_NEGEXP;
                    end else if (arith_c && (a_ovf_c || b_ovf_c)) begin
                        early_err_c = ERR_OVF;
                    end else if (op_c == OP_LOAD) begin
                        if (a_ovf_c) begin
                            early_err_c = ERR_OVF;
                        end else begin
                            acc_d       = cmd_a;
                            early_res_c = cmd_a;
                        end
                    end else if (op_c == OP_CLEAR) begin
                        acc_d   = '0;
                        clear_c = 1'b1;
                    end else begin
                        early_c     = 1'b0;
                        dp_a_d      = eff_a_c;
                        dp_b_d      = cmd_b;
                        dp_op_d     = cmd_op;
                        cnt_d       = '0;
                        cmd_ready_d = 1'b0;
                        state_d     = ST_EXEC;
                    end

                    if (early_c) begin
                        state_d      = ST_RESP;
                        cmd_ready_d  = 1'b0;
                        rsp_valid_d  = 1'b1;
                        rsp_result_d = early_res_c;
                        rsp_err_d    = early_err_c;
                        if (clear_c) begin
                            err_cnt_d = '0;
                        end else if (early_err_c != ERR_OK) begin
                            err_cnt_d = sat_inc8(err_cnt_q);
                        end
                    end
                end
            end

            ST_EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    if (r_ovf_c) begin
                        rsp_result_d = '0;
                        rsp_err_d    = ERR_OVF;
                        err_cnt_d    = sat_inc8(err_cnt_q);
                    end else begin
                        rsp_result_d = dp_result;
                        rsp_err_d    = ERR_OK;
                        acc_d        = dp_result;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= ERR_OK;
            dp_a_q       <= '0;
            dp_b_q       <= '0;
            dp_op_q      <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            dp_a_q       <= dp_a_d;
            dp_b_q       <= dp_b_d;
            dp_op_q      <= dp_op_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign dp_a       = dp_a_q;
    assign dp_b       = dp_b_q;
    assign dp_op      = dp_op_q;
    assign acc_value  = acc_q;
    assign err_cnt    = err_cnt_q;

endmodule
